led_fade_scheduler: RTL and testbench

- Per-LED brightness controller sitting between the rotary-encoder front end (debounced step pulses) and the four LED outputs of the light manager.
- Holds one target and one current PWM level per channel, and routes encoder steps to the currently selected channel.
- Fades each current level toward its target using a single shared up/down unit, time-shared round-robin across the channels.
- Drives four PWM outputs from one free-running counter.

---
 rtl/led_fade_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_led_fade_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_fade_scheduler.sv
// ----------------------------------------------------------------------------
// led_fade_scheduler
//
// Per-LED brightness controller for a four-channel light manager. Debounced
// encoder steps adjust the target level of the selected channel. A single
// shared up/down unit fades each current level toward its target, one
// channel per cycle in a round-robin sweep started on every fade tick. The
// four LED outputs are PWM-modulated from one free-running counter.
//
// Parameters:
//   CLOCK_FREQ_MHZ  clock frequency in MHz (1..655)
//   PWM_VALUE_SIZE  width of the level registers and of the PWM counter
//   BRIGHTNESS_INC  target change per accepted encoder step
//   RAMP_STEP_US    interval between fade ticks in microseconds
//
// Ports:
//   clk_i         in   system clock
//   rst_n_i       in   asynchronous active-low reset
//   step_valid_i  in   one-cycle pulse, one encoder detent
//   step_dir_i    in   1 = brighter, 0 = dimmer (sampled with step_valid_i)
//   sel_next_i    in   one-cycle pulse, advance the selected channel
//   leds_o        out  registered PWM outputs, one per channel
//   sel_o         out  index of the selected channel
//   level_o       out  target level of the selected channel
//   busy_o        out  high while any current level differs from its target
//
// Optional build macro:
//   LED_FADE_SELECT_BLINK_EN  when defined, the newly selected channel's
//   output is forced off for two tick periods after each sel_next_i as a
//   selection indicator. Levels are not affected.
// ----------------------------------------------------------------------------
module led_fade_scheduler #(
    parameter int CLOCK_FREQ_MHZ = 100,
    parameter int PWM_VALUE_SIZE = 8,
    parameter int BRIGHTNESS_INC = 5,
    parameter int RAMP_STEP_US   = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      step_valid_i,
    input  logic                      step_dir_i,
    input  logic                      sel_next_i,
    output logic [3:0]                leds_o,
    output logic [1:0]                sel_o,
    output logic [PWM_VALUE_SIZE-1:0] level_o,
    output logic                      busy_o
);

    localparam int W           = PWM_VALUE_SIZE;
    localparam int TICK_PERIOD = CLOCK_FREQ_MHZ * RAMP_STEP_US;
    localparam int TCW         = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_PERIOD - 1);
    // Step arithmetic runs one bit wider so overflow/underflow is visible.
    localparam logic [W:0] INC_W = (W + 1)'(BRIGHTNESS_INC);
    localparam logic [W:0] MAX_W = {1'b0, {W{1'b1}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } state_e;

    // Saturating target adjustment for one encoder step.
    function automatic logic [W-1:0] step_target(input logic [W-1:0] tgt,
                                                 input logic       up);
        logic [W:0] wide;
        if (up) begin
            wide = {1'b0, tgt} + INC_W;
            if (wide > MAX_W) begin
                wide = MAX_W;
            end else begin
                wide = wide;
            end
        end else begin
            wide = {1'b0, tgt} - INC_W;
            // A set MSB means the subtraction borrowed: clamp at zero.
            if (wide[W]) begin
                wide = {(W + 1){1'b0}};
            end else begin
                wide = wide;
            end
        end
        return wide[W-1:0];
    endfunction

    // Shared up/down unit: move one LSB toward the target, hold if equal.
    function automatic logic [W-1:0] fade_toward(input logic [W-1:0] cur,
                                                 input logic [W-1:0] tgt);
        logic [W-1:0] res;
        if (cur < tgt) begin
            res = cur + {{(W - 1){1'b0}}, 1'b1};
        end else if (cur > tgt) begin
            res = cur - {{(W - 1){1'b0}}, 1'b1};
        end else begin
            res = cur;
        end
        return res;
    endfunction

    logic [W-1:0]   tgt_q [4];
    logic [W-1:0]   cur_q [4];
    logic [1:0]     sel_q;
    logic [1:0]     ch_q;
    state_e         state_q;
    logic [TCW-1:0] tick_cnt_q;
    logic [W-1:0]   pwm_cnt_q;
    logic [3:0]     leds_q;
    logic           busy_q;

    logic           tick_s;
    logic [W-1:0]   tgt_step_d;
    logic [W-1:0]   fade_d;
    logic [3:0]     leds_d;
    logic           busy_d;
    logic [3:0]     blink_mask_s;

    assign tick_s  = (tick_cnt_q == TICK_LAST);
    assign sel_o   = sel_q;
    assign level_o = tgt_q[sel_q];
    assign leds_o  = leds_q;
    assign busy_o  = busy_q;

    // Next target for the selected channel and next current level for the swept channel.
    always_comb begin
        tgt_step_d = step_target(tgt_q[sel_q], step_dir_i);
        fade_d     = fade_toward(cur_q[ch_q], tgt_q[ch_q]);
    end

    // Target levels: an accepted step updates the selected channel.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 4; k++) begin
                tgt_q[k] <= {W{1'b0}};
            end
        end else if (step_valid_i) begin
            // Uses the pre-advance sel_q, so a simultaneous sel_next_i
            // still lands the step on the old channel.
            tgt_q[sel_q] <= tgt_step_d;
        end
    end

    // Channel selection, wrapping 3 -> 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q <= 2'd0;
        end else if (sel_next_i) begin
            sel_q <= sel_q + 2'd1;
        end
    end

    // Free-running fade tick divider and PWM counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_cnt_q <= {TCW{1'b0}};
            pwm_cnt_q  <= {W{1'b0}};
        end else begin
            pwm_cnt_q <= pwm_cnt_q + {{(W - 1){1'b0}}, 1'b1};
            if (tick_s) begin
                tick_cnt_q <= {TCW{1'b0}};
            end else begin
                tick_cnt_q <= tick_cnt_q + {{(TCW - 1){1'b0}}, 1'b1};
            end
        end
    end

    // Fade sequencer: on a tick, sweep channels 0..3 through the shared unit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ch_q    <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                cur_q[k] <= {W{1'b0}};
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_s && busy_q) begin
                        state_q <= ST_UPD;
                        ch_q    <= 2'd0;
                    end
                end
                ST_UPD: begin
                    // Ticks are ignored here; the sweep is far shorter
                    // than a tick period.
                    cur_q[ch_q] <= fade_d;
                    ch_q        <= ch_q + 2'd1;
                    if (ch_q == 2'd3) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ch_q    <= 2'd0;
                end
            endcase
        end
    end

    // Busy flag and PWM comparison, computed from the current registers.
    always_comb begin
        busy_d = 1'b0;
        leds_d = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (cur_q[k] != tgt_q[k]) begin
                busy_d = 1'b1;
            end else begin
                busy_d = busy_d;
            end
            leds_d[k] = (pwm_cnt_q < cur_q[k]) && !blink_mask_s[k];
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            leds_q <= 4'b0000;
            busy_q <= 1'b0;
        end else begin
            leds_q <= leds_d;
            busy_q <= busy_d;
        end
    end

`ifdef LED_FADE_SELECT_BLINK_EN
    localparam int BLINK_CYC = 2 * TICK_PERIOD;
    localparam int BCW       = $clog2(BLINK_CYC + 1);

    logic [BCW-1:0] blink_cnt_q;
    logic [1:0]     blink_ch_q;

    // Selection flash: blank the newly selected channel for two tick periods.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blink_cnt_q <= {BCW{1'b0}};
            blink_ch_q  <= 2'd0;
        end else if (sel_next_i) begin
            // A further selection restarts the flash on the new channel.
            blink_cnt_q <= BCW'(BLINK_CYC);
            blink_ch_q  <= sel_q + 2'd1;
        end else if (blink_cnt_q != {BCW{1'b0}}) begin
            blink_cnt_q <= blink_cnt_q - {{(BCW - 1){1'b0}}, 1'b1};
        end
    end

    // Decode the flash into a per-channel output mask.
    always_comb begin
        blink_mask_s = 4'b0000;
        if (blink_cnt_q != {BCW{1'b0}}) begin
            blink_mask_s[blink_ch_q] = 1'b1;
        end else begin
            blink_mask_s = 4'b0000;
        end
    end
`else
    assign blink_mask_s = 4'b0000;
`endif

endmodule

// File: tb/tb_led_fade_scheduler.sv
// ----------------------------------------------------------------------------
// Directed testbench for led_fade_scheduler (default parameters: 100 MHz,
// 10 us fade tick = 1000 cycles, 8-bit levels, step of 5).
// Inputs are driven on the falling clock edge and outputs sampled there.
// ----------------------------------------------------------------------------
module tb_led_fade_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_valid = 1'b0;
    logic       step_dir = 1'b0;
    logic       sel_next = 1'b0;
    logic [3:0] leds;
    logic [1:0] sel;
    logic [7:0] level;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc;
    int duty_cnt [4];

    led_fade_scheduler dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .step_valid_i (step_valid),
        .step_dir_i   (step_dir),
        .sel_next_i   (sel_next),
        .leds_o       (leds),
        .sel_o        (sel),
        .level_o      (level),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; equals the DUT tick phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic dir);
        @(negedge clk);
        step_valid = 1'b1;
        step_dir   = dir;
        @(negedge clk);
        step_valid = 1'b0;
    endtask

    task automatic seln();
        @(negedge clk);
        sel_next = 1'b1;
        @(negedge clk);
        sel_next = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // High samples per channel over one full 256-cycle PWM period.
    task automatic measure();
        for (int k = 0; k < 4; k++) duty_cnt[k] = 0;
        repeat (256) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) duty_cnt[k] += int'(leds[k]);
        end
    endtask

    initial begin
        // Reset state (held low for 1 us)
        repeat (50) @(negedge clk);
        chk("rst_leds", leds, 0);
        chk("rst_sel", sel, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        repeat (50) @(negedge clk);
        rst_n = 1'b1;

        // Basic step: 3 x up on channel 0 -> target 15, fade 1 LSB per tick
        step(1'b1); step(1'b1); step(1'b1);
        chk("step_level15", level, 15);
        @(negedge clk);
        chk("step_busy", busy, 1);
        wait_until(10500);
        measure();
        chk("fade10_duty0", duty_cnt[0], 10);
        chk("fade10_busy", busy, 1);
        wait_until(14500);
        chk("fade14_busy", busy, 1);
        wait_until(15500);
        chk("fade15_busy", busy, 0);
        measure();
        chk("fade15_duty0", duty_cnt[0], 15);

        // Saturation high and low
        repeat (60) step(1'b1);
        chk("sat_hi", level, 255);
        step(1'b1);
        chk("sat_hi_hold", level, 255);
        step(1'b0);
        chk("dec_250", level, 250);
        repeat (59) step(1'b0);
        chk("sat_lo", level, 0);
        step(1'b0);
        chk("sat_lo_hold", level, 0);

        // Select wrap
        seln(); chk("sel_1", sel, 1);
        seln(); chk("sel_2", sel, 2);
        seln(); chk("sel_3", sel, 3);
        seln(); chk("sel_wrap", sel, 0);
        seln();
        // Step and select in the same cycle on channel 1
        @(negedge clk);
        step_valid = 1'b1; step_dir = 1'b1; sel_next = 1'b1;
        @(negedge clk);
        step_valid = 1'b0; sel_next = 1'b0;
        chk("simul_sel", sel, 2);
        chk("simul_tgt2", level, 0);
        seln(); seln(); seln();
        chk("simul_back_sel", sel, 1);
        chk("simul_tgt1", level, 5);

        // Concurrent fade: targets {10, 20, 0, 5}
        do_reset();
        chk("rst2_sel", sel, 0);
        chk("rst2_level", level, 0);
        step(1'b1); step(1'b1);
        seln();
        step(1'b1); step(1'b1); step(1'b1); step(1'b1);
        chk("conc_tgt1", level, 20);
        seln(); seln();
        step(1'b1);
        chk("conc_tgt3", level, 5);
        wait_until(10500);
        measure();
        chk("conc10_ch0", duty_cnt[0], 10);
        chk("conc10_ch1", duty_cnt[1], 10);
        chk("conc10_ch2", duty_cnt[2], 0);
        chk("conc10_ch3", duty_cnt[3], 5);
        chk("conc10_busy", busy, 1);
        wait_until(20500);
        chk("conc20_busy", busy, 0);
        measure();
        chk("conc20_ch0", duty_cnt[0], 10);
        chk("conc20_ch1", duty_cnt[1], 20);
        chk("conc20_ch2", duty_cnt[2], 0);
        chk("conc20_ch3", duty_cnt[3], 5);

        // Reset in the middle of a fade sweep
        seln();
        step(1'b1); step(1'b1); step(1'b1);
        chk("mid_tgt0", level, 25);
        seln();
        @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        chk("mid_sel_pre", sel, 1);
        wait_until(21001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_leds", leds, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_lvl0", level, 0);
        seln(); chk("post_lvl1", level, 0);
        seln(); chk("post_lvl2", level, 0);
        seln(); chk("post_lvl3", level, 0);
        measure();
        chk("post_duty0", duty_cnt[0], 0);
        chk("post_duty1", duty_cnt[1], 0);
        chk("post_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
